// File: rtl/sd_spi_block_engine.sv
// SD-card SPI transaction engine: init clocks, CRC7-framed commands with R1/R3/R7
// polling, multi-block read and write streams with token, response and busy handling.
module sd_spi_block_engine #(
    parameter int unsigned BLOCK_BYTES  = 512,
    parameter int unsigned INIT_BYTES   = 10,
    parameter int unsigned CMD_TIMEOUT  = 65535,
    parameter int unsigned BUSY_TIMEOUT = 65535,
    parameter int unsigned CRC7_EN      = 1
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [15:0] spi_clk_div,
    input  logic        cmd_req,
    input  logic [47:0] cmd,
    input  logic [7:0]  cmd_r1,
    input  logic [15:0] cmd_data_len,
    output logic        cmd_req_ack,
    output logic        cmd_req_error,
    input  logic [15:0] blk_count,
    input  logic        rd_req,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_ack,
    input  logic        wr_req,
    input  logic        wr_multi,
    output logic        wr_data_rd,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        xfer_error,
    output logic        nCS_ctrl,
    output logic [15:0] clk_div,
    output logic        spi_wr_req,
    output logic [7:0]  spi_data_in,
    input  logic        spi_wr_ack,
    input  logic [7:0]  spi_data_out
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_BYTES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(BLOCK_BYTES - 1);

    typedef enum logic [4:0] {
        S_IDLE, S_INIT, S_WAIT, S_CMD_PRE, S_CMD, S_CMD_POLL, S_CMD_DATA,
        S_RD_TOKEN, S_RD_DATA, S_RD_CRC,
        S_WR_TOKEN, S_WR_FETCH, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY, S_WR_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] blk_q, blk_d;
    logic             multi_q, multi_d;
    logic             cs_q, cs_d;
    logic             req_q, req_d;
    logic [7:0]       tx_q, tx_d;
    logic [15:0]      clk_div_q, clk_div_d;
    logic             cmd_ack_q, cmd_ack_d;
    logic             cmd_err_q, cmd_err_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_ack_q, rd_ack_d;
    logic             wr_ack_q, wr_ack_d;
    logic             wr_rd_q, wr_rd_d;
    logic             xfer_err_q, xfer_err_d;

    logic             done_c;
    logic             send_c;
    logic [7:0]       send_byte_c;
    logic [39:0]      frame_c;
    logic [7:0]       crc_byte_c;
    logic [7:0]       frame_byte_c;
    logic [CNT_W-1:0] blk_init_c;

    // CRC7 (x^7 + x^3 + 1), MSB first, zero init
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign done_c     = req_q & spi_wr_ack;
    assign frame_c    = {cmd[47:40] | 8'h40, cmd[39:8]};
    assign crc_byte_c = (CRC7_EN != 0) ? {crc7(frame_c), 1'b1} : cmd[7:0];
    assign blk_init_c = (blk_count == '0) ? CNT_W'(1) : blk_count;

    always_comb begin
        case (cnt_q[2:0])
            3'd0:    frame_byte_c = frame_c[39:32];
            3'd1:    frame_byte_c = frame_c[31:24];
            3'd2:    frame_byte_c = frame_c[23:16];
            3'd3:    frame_byte_c = frame_c[15:8];
            3'd4:    frame_byte_c = frame_c[7:0];
            default: frame_byte_c = crc_byte_c;
        endcase
    end

    // Next-state: each byte state requests one SPI byte while req is low and acts on its ack
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        multi_d     = multi_q;
        cs_d        = cs_q;
        req_d       = req_q;
        tx_d        = tx_q;
        clk_div_d   = clk_div_q;
        cmd_err_d   = cmd_err_q;
        xfer_err_d  = xfer_err_q;
        rd_data_d   = rd_data_q;
        cmd_ack_d   = 1'b0;
        rd_ack_d    = 1'b0;
        wr_ack_d    = 1'b0;
        rd_valid_d  = 1'b0;
        wr_rd_d     = 1'b0;
        send_c      = 1'b0;
        send_byte_c = 8'hFF;

        if (done_c) req_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_div_d = spi_clk_div;
                cs_d      = 1'b1;
                cnt_d     = '0;
                state_d   = S_INIT;
            end
            S_INIT: begin
                send_c = 1'b1;
                if (done_c) begin
                    if (cnt_q == INIT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                clk_div_d = spi_clk_div;
                cnt_d     = '0;
                // ignore requests during the ack cycle; requesters drop on ack
                if (!(cmd_ack_q || rd_ack_q || wr_ack_q)) begin
                    if (cmd_req) begin
                        cmd_err_d = 1'b0;
                        state_d   = S_CMD_PRE;
                    end else if (rd_req) begin
                        xfer_err_d = 1'b0;
                        blk_d      = blk_init_c;
                        state_d    = S_RD_TOKEN;
                    end else if (wr_req) begin
                        xfer_err_d = 1'b0;
                        blk_d      = blk_init_c;
                        multi_d    = wr_multi;
                        state_d    = S_WR_TOKEN;
                    end
                end
            end
            S_CMD_PRE: begin
                cs_d   = 1'b1;
                send_c = 1'b1;
                if (done_c) state_d = S_CMD;
            end
            S_CMD: begin
                cs_d        = 1'b0;
                send_c      = 1'b1;
                send_byte_c = frame_byte_c;
                if (done_c) begin
                    if (cnt_q == CNT_W'(5)) begin
                        cnt_d   = '0;
                        state_d = S_CMD_POLL;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CMD_POLL: begin
                send_c = 1'b1;
                if (done_c) begin
                    if (spi_data_out == cmd_r1) begin
                        cnt_d = '0;
                        if (cmd_data_len != '0) state_d = S_CMD_DATA;
                        else begin
                            cmd_ack_d = 1'b1;
                            state_d   = S_WAIT;
                        end
                    end else if (!spi_data_out[7] || cnt_q == CMD_LAST) begin
                        cmd_err_d = 1'b1;
                        cmd_ack_d = 1'b1;
                        state_d   = S_WAIT;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CMD_DATA: begin
                send_c = 1'b1;
                if (done_c) begin
                    if (cnt_q == cmd_data_len - 16'd1) begin
                        cmd_ack_d = 1'b1;
                        state_d   = S_WAIT;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD_TOKEN: begin
                send_c = 1'b1;
                if (done_c) begin
                    if (spi_data_out == 8'hFE) begin
                        cnt_d   = '0;
                        state_d = S_RD_DATA;
                    end else if (spi_data_out[7:4] == 4'h0 || cnt_q == CMD_LAST) begin
                        xfer_err_d = 1'b1;
                        rd_ack_d   = 1'b1;
                        state_d    = S_WAIT;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD_DATA: begin
                send_c = 1'b1;
                if (done_c) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = spi_data_out;
                    if (cnt_q == BLK_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RD_CRC;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD_CRC: begin
                send_c = 1'b1;
                if (done_c) begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d = '0;
                        if (blk_q == CNT_W'(1)) begin
                            rd_ack_d = 1'b1;
                            state_d  = S_WAIT;
                        end else begin
                            blk_d   = blk_q - CNT_W'(1);
                            state_d = S_RD_TOKEN;
                        end
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR_TOKEN: begin
                send_c      = 1'b1;
                send_byte_c = multi_q ? 8'hFC : 8'hFE;
                if (done_c) begin
                    cnt_d   = '0;
                    wr_rd_d = 1'b1;
                    state_d = S_WR_FETCH;
                end
            end
            S_WR_FETCH: state_d = S_WR_DATA;
            S_WR_DATA: begin
                send_c      = 1'b1;
                send_byte_c = wr_data;
                if (done_c) begin
                    if (cnt_q == BLK_LAST) begin
                        cnt_d   = '0;
                        state_d = S_WR_CRC;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        wr_rd_d = 1'b1;
                        state_d = S_WR_FETCH;
                    end
                end
            end
            S_WR_CRC: begin
                send_c = 1'b1;
                if (done_c) begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_WR_RESP;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR_RESP: begin
                send_c = 1'b1;
                if (done_c) begin
                    if (!spi_data_out[4] && spi_data_out[4:0] == 5'h05) begin
                        cnt_d   = '0;
                        state_d = S_WR_BUSY;
                    end else if (!spi_data_out[4] || cnt_q == CMD_LAST) begin
                        xfer_err_d = 1'b1;
                        wr_ack_d   = 1'b1;
                        state_d    = S_WAIT;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // blk_q == 0 marks the busy poll that follows the stop token
            S_WR_BUSY: begin
                send_c = 1'b1;
                if (done_c) begin
                    if (spi_data_out == 8'hFF) begin
                        cnt_d = '0;
                        if (blk_q == '0 || (blk_q == CNT_W'(1) && !multi_q)) begin
                            wr_ack_d = 1'b1;
                            state_d  = S_WAIT;
                        end else if (blk_q == CNT_W'(1)) begin
                            blk_d   = '0;
                            state_d = S_WR_STOP;
                        end else begin
                            blk_d   = blk_q - CNT_W'(1);
                            state_d = S_WR_TOKEN;
                        end
                    end else if (cnt_q == BUSY_LAST) begin
                        xfer_err_d = 1'b1;
                        wr_ack_d   = 1'b1;
                        state_d    = S_WAIT;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR_STOP: begin
                send_c      = 1'b1;
                send_byte_c = (cnt_q == '0) ? 8'hFD : 8'hFF;
                if (done_c) begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_WR_BUSY;
                    end else cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (send_c && !req_q) begin
            req_d = 1'b1;
            tx_d  = send_byte_c;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            blk_q      <= '0;
            multi_q    <= 1'b0;
            cs_q       <= 1'b1;
            req_q      <= 1'b0;
            tx_q       <= 8'hFF;
            clk_div_q  <= '0;
            cmd_ack_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ack_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_rd_q    <= 1'b0;
            xfer_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            multi_q    <= multi_d;
            cs_q       <= cs_d;
            req_q      <= req_d;
            tx_q       <= tx_d;
            clk_div_q  <= clk_div_d;
            cmd_ack_q  <= cmd_ack_d;
            cmd_err_q  <= cmd_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ack_q   <= rd_ack_d;
            wr_ack_q   <= wr_ack_d;
            wr_rd_q    <= wr_rd_d;
            xfer_err_q <= xfer_err_d;
        end
    end

    assign nCS_ctrl      = cs_q;
    assign clk_div       = clk_div_q;
    assign spi_wr_req    = req_q;
    assign spi_data_in   = tx_q;
    assign cmd_req_ack   = cmd_ack_q;
    assign cmd_req_error = cmd_err_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign rd_ack        = rd_ack_q;
    assign wr_ack        = wr_ack_q;
    assign wr_data_rd    = wr_rd_q;
    assign xfer_error    = xfer_err_q;

endmodule

// File: tb/tb_sd_spi_block_engine.sv
// Bench for sd_spi_block_engine: SPI slave model with 4-cycle byte latency, command
// vector table, and directed read/write/priority/reset sequences.
`timescale 1ns/1ps
module tb_sd_spi_block_engine;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] spi_clk_div = 16'h0004;
    logic        cmd_req = 1'b0;
    logic [47:0] cmd = '0;
    logic [7:0]  cmd_r1 = '0;
    logic [15:0] cmd_data_len = '0;
    logic        cmd_req_ack, cmd_req_error;
    logic [15:0] blk_count = 16'd1;
    logic        rd_req = 1'b0;
    logic        rd_valid, rd_ack;
    logic [7:0]  rd_data;
    logic        wr_req = 1'b0;
    logic        wr_multi = 1'b0;
    logic        wr_data_rd, wr_ack, xfer_error;
    logic [7:0]  wr_data = '0;
    logic        nCS_ctrl;
    logic [15:0] clk_div;
    logic        spi_wr_req;
    logic [7:0]  spi_data_in;
    logic        spi_wr_ack = 1'b0;
    logic [7:0]  spi_data_out = '0;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] tx_log[$];
    logic       cs_log[$];
    logic [7:0] rx_q[$];
    logic [7:0] rd_got[$];
    int         wr_rd_cnt = 0;
    int         rd_ack_n = 0;

    sd_spi_block_engine #(
        .BLOCK_BYTES(512), .INIT_BYTES(10), .CMD_TIMEOUT(8), .BUSY_TIMEOUT(16), .CRC7_EN(1)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .spi_clk_div(spi_clk_div),
        .cmd_req(cmd_req), .cmd(cmd), .cmd_r1(cmd_r1), .cmd_data_len(cmd_data_len),
        .cmd_req_ack(cmd_req_ack), .cmd_req_error(cmd_req_error),
        .blk_count(blk_count), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_ack(rd_ack), .wr_req(wr_req), .wr_multi(wr_multi), .wr_data_rd(wr_data_rd),
        .wr_data(wr_data), .wr_ack(wr_ack), .xfer_error(xfer_error), .nCS_ctrl(nCS_ctrl),
        .clk_div(clk_div), .spi_wr_req(spi_wr_req), .spi_data_in(spi_data_in),
        .spi_wr_ack(spi_wr_ack), .spi_data_out(spi_data_out)
    );

    always #5 sys_clk = ~sys_clk;

    // SPI slave: log each requested byte, ack 4 cycles later with the next queued reply
    initial begin
        bit aborted;
        forever begin
            @(posedge sys_clk);
            #1;
            if (spi_wr_req && !rst) begin
                tx_log.push_back(spi_data_in);
                cs_log.push_back(nCS_ctrl);
                aborted = 1'b0;
                repeat (4) begin
                    @(posedge sys_clk);
                    if (rst) aborted = 1'b1;
                end
                if (!aborted) begin
                    #1;
                    spi_data_out = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hFF;
                    spi_wr_ack = 1'b1;
                    @(posedge sys_clk);
                    #1 spi_wr_ack = 1'b0;
                end
            end
        end
    end

    // Collect read strobes and serve write data one cycle after each fetch
    always @(negedge sys_clk) begin
        if (rd_valid) rd_got.push_back(rd_data);
        if (rd_ack) rd_ack_n = rd_ack_n + 1;
        if (wr_data_rd) begin
            wr_data = 8'(wr_rd_cnt * 3 + 1);
            wr_rd_cnt = wr_rd_cnt + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tx_at(input int k);
        return (k < tx_log.size()) ? tx_log[k] : 8'hxx;
    endfunction

    function automatic logic cs_at(input int k);
        return (k < cs_log.size()) ? cs_log[k] : 1'bx;
    endfunction

    task automatic clear_logs();
        tx_log.delete();
        cs_log.delete();
        rx_q.delete();
    endtask

    task automatic wait_ack(input int sel, input int budget, output logic err);
        bit seen;
        seen = 1'b0;
        err = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (sel == 0 && cmd_req_ack) begin seen = 1'b1; err = cmd_req_error; break; end
            if (sel == 1 && rd_ack)      begin seen = 1'b1; err = xfer_error; break; end
            if (sel == 2 && wr_ack)      begin seen = 1'b1; err = xfer_error; break; end
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ack_timeout sel=%0d: no ack within %0d cycles", sel, budget);
        end
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_ncs"}, 32'(nCS_ctrl), 32'd1);
        chk({p, "_spi_req"}, 32'(spi_wr_req), 32'd0);
        chk({p, "_spi_data_in"}, 32'(spi_data_in), 32'hFF);
        chk({p, "_clk_div"}, 32'(clk_div), 32'd0);
        chk({p, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({p, "_flags"}, 32'({cmd_req_ack, cmd_req_error, rd_ack, rd_valid,
                                wr_ack, wr_data_rd, xfer_error}), 32'd0);
    endtask

    task automatic check_init(input string p);
        int bad;
        for (int i = 0; i < 400 && tx_log.size() < 10; i++) @(negedge sys_clk);
        repeat (40) @(negedge sys_clk);
        chk({p, "_init_count"}, 32'(tx_log.size()), 32'd10);
        bad = 0;
        foreach (tx_log[k]) if (tx_log[k] !== 8'hFF || cs_log[k] !== 1'b1) bad++;
        chk({p, "_init_ff_cs1"}, 32'(bad), 32'd0);
        chk({p, "_init_clk_div"}, 32'(clk_div), 32'h0004);
    endtask

    typedef struct {
        logic [47:0] cmd;
        logic [7:0]  r1;
        logic [15:0] dlen;
        int          nff;
        logic [7:0]  resp;
        bit          never;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b5;
        logic        exp_err;
        int          exp_bytes;
    } cvec_t;

    cvec_t vec[6];

    initial begin
        logic err;
        int   bad, base, rbase;
        logic [7:0] exp_q[$];

        vec[0] = '{48'h40_0000_0000_95, 8'h01, 16'd0, 2, 8'h01, 1'b0, 8'h40, 8'h95, 1'b0, 10};
        vec[1] = '{48'h48_0000_01AA_00, 8'h01, 16'd4, 1, 8'h01, 1'b0, 8'h48, 8'h87, 1'b0, 13};
        vec[2] = '{48'h77_0000_0000_00, 8'h00, 16'd0, 0, 8'h05, 1'b0, 8'h77, 8'h65, 1'b1, 8};
        vec[3] = '{48'h29_4000_0000_00, 8'h00, 16'd0, 0, 8'h00, 1'b0, 8'h69, 8'h77, 1'b0, 8};
        vec[4] = '{48'h40_0000_0000_00, 8'h01, 16'd0, 0, 8'h00, 1'b1, 8'h40, 8'h95, 1'b1, 15};
        vec[5] = '{48'h00_0000_0000_00, 8'h01, 16'd0, 3, 8'h01, 1'b0, 8'h40, 8'h95, 1'b0, 11};

        repeat (2) @(negedge sys_clk);
        check_reset_vals("por");
        rst = 1'b0;
        check_init("por");

        // Command vectors
        for (int v = 0; v < 6; v++) begin
            clear_logs();
            repeat (7) rx_q.push_back(8'hFF);
            repeat (vec[v].nff) rx_q.push_back(8'hFF);
            if (!vec[v].never) rx_q.push_back(vec[v].resp);
            repeat (int'(vec[v].dlen)) rx_q.push_back(8'h3C);
            cmd = vec[v].cmd;
            cmd_r1 = vec[v].r1;
            cmd_data_len = vec[v].dlen;
            cmd_req = 1'b1;
            wait_ack(0, 400, err);
            cmd_req = 1'b0;
            repeat (3) @(negedge sys_clk);
            chk($sformatf("v%0d_err", v), 32'(err), 32'(vec[v].exp_err));
            chk($sformatf("v%0d_bytes", v), 32'(tx_log.size()), 32'(vec[v].exp_bytes));
            chk($sformatf("v%0d_pre", v), 32'({cs_at(0), tx_at(0)}), 32'h1FF);
            chk($sformatf("v%0d_b0", v), 32'({cs_at(1), tx_at(1)}), 32'(vec[v].exp_b0));
            chk($sformatf("v%0d_mid", v), {tx_at(2), tx_at(3), tx_at(4), tx_at(5)}, vec[v].cmd[39:8]);
            chk($sformatf("v%0d_b5", v), 32'(tx_at(6)), 32'(vec[v].exp_b5));
        end

        // Two-block read
        clear_logs();
        rbase = rd_got.size();
        for (int b = 0; b < 2; b++) begin
            repeat (3) rx_q.push_back(8'hFF);
            rx_q.push_back(8'hFE);
            for (int i = 0; i < 512; i++) rx_q.push_back(8'(b * 37 + i * 5 + 3));
            rx_q.push_back(8'hA5);
            rx_q.push_back(8'h5A);
        end
        blk_count = 16'd2;
        rd_req = 1'b1;
        wait_ack(1, 20000, err);
        rd_req = 1'b0;
        chk("rd_err", 32'(err), 32'd0);
        chk("rd_count", 32'(rd_got.size() - rbase), 32'd1024);
        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (rbase + k >= rd_got.size() || rd_got[rbase + k] !== 8'((k / 512) * 37 + (k % 512) * 5 + 3)) bad++;
        chk("rd_data_match", 32'(bad), 32'd0);
        chk("rd_tx_bytes", 32'(tx_log.size()), 32'd1036);
        bad = 0;
        foreach (tx_log[k]) if (tx_log[k] !== 8'hFF) bad++;
        chk("rd_tx_all_ff", 32'(bad), 32'd0);

        // Three-block multi-write
        clear_logs();
        base = wr_rd_cnt;
        for (int b = 0; b < 3; b++) begin
            repeat (515) rx_q.push_back(8'hFF);
            rx_q.push_back(8'hE5);
            rx_q.push_back(8'h00);
            rx_q.push_back(8'h00);
            rx_q.push_back(8'hFF);
        end
        exp_q.delete();
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back(8'hFC);
            for (int i = 0; i < 512; i++) exp_q.push_back(8'((base + b * 512 + i) * 3 + 1));
            repeat (6) exp_q.push_back(8'hFF);
        end
        exp_q.push_back(8'hFD);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        blk_count = 16'd3;
        wr_multi = 1'b1;
        wr_req = 1'b1;
        wait_ack(2, 30000, err);
        wr_req = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_fetch_count", 32'(wr_rd_cnt - base), 32'd1536);
        chk("wr_tx_bytes", 32'(tx_log.size()), 32'd1560);
        bad = 0;
        foreach (exp_q[k]) if (tx_at(k) !== exp_q[k]) bad++;
        chk("wr_tx_stream", 32'(bad), 32'd0);
        chk("wr_tokens", {tx_at(0), tx_at(519), tx_at(1038), tx_at(1557)}, 32'hFCFCFCFD);

        // Multi-write rejected on block 2
        clear_logs();
        base = wr_rd_cnt;
        repeat (515) rx_q.push_back(8'hFF);
        rx_q.push_back(8'hE5);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'hFF);
        repeat (515) rx_q.push_back(8'hFF);
        rx_q.push_back(8'h0B);
        wr_req = 1'b1;
        wait_ack(2, 30000, err);
        wr_req = 1'b0;
        repeat (40) @(negedge sys_clk);
        chk("wrerr_flag", 32'(err), 32'd1);
        chk("wrerr_fetch_count", 32'(wr_rd_cnt - base), 32'd1024);
        chk("wrerr_tx_bytes", 32'(tx_log.size()), 32'd1035);
        chk("wrerr_token2", 32'(tx_at(519)), 32'hFC);
        wr_multi = 1'b0;

        // cmd_req and rd_req together: command first, then read hits an error token
        clear_logs();
        repeat (7) rx_q.push_back(8'hFF);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h05);
        base = rd_ack_n;
        rbase = rd_got.size();
        cmd = 48'h40_0000_0000_95;
        cmd_r1 = 8'h01;
        cmd_data_len = 16'd0;
        blk_count = 16'd1;
        cmd_req = 1'b1;
        rd_req = 1'b1;
        wait_ack(0, 400, err);
        cmd_req = 1'b0;
        chk("prio_cmd_err", 32'(err), 32'd0);
        chk("prio_no_rd_first", 32'(rd_ack_n - base), 32'd0);
        chk("prio_frame_b0", 32'({cs_at(1), tx_at(1)}), 32'h040);
        wait_ack(1, 400, err);
        rd_req = 1'b0;
        chk("prio_rd_err_token", 32'(err), 32'd1);
        chk("prio_rd_no_data", 32'(rd_got.size() - rbase), 32'd0);
        chk("prio_total_bytes", 32'(tx_log.size()), 32'd9);

        // Reset in the middle of a data block
        clear_logs();
        rx_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) rx_q.push_back(8'(i));
        rbase = rd_got.size();
        rd_req = 1'b1;
        for (int i = 0; i < 1000 && rd_got.size() < rbase + 8; i++) @(negedge sys_clk);
        chk("mid_rd_progress", 32'(rd_got.size() >= rbase + 8), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        rd_req = 1'b0;
        repeat (3) @(negedge sys_clk);
        clear_logs();
        rst = 1'b0;
        check_init("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
